// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous ROM and feeds the decoder one word per cycle.
// Jumps and interrupt entry cost one bubble; stall freezes the PC state and shows NOP to the decoder.
module fetch_unit #(
  parameter logic [10:0] RESET_VECTOR = 11'h000,
  parameter logic [10:0] IRQ_VECTOR   = 11'h010,
  parameter logic [23:0] NOP_WORD     = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] rom_addr,
  input  logic [23:0] rom_q,
  output logic [23:0] rom_data,
  output logic [10:0] rom_pc,
  input  logic        rom_jump_enable,
  input  logic [10:0] rom_jump_data,
  input  logic        stall,
  input  logic        irq,
  input  logic        interrupt_clear_status,
  output logic        irq_push_enable,
  output logic [10:0] irq_push_data,
  output logic        in_isr
);

  logic [10:0] fetch_pc;
  logic [10:0] exec_pc;
  logic        exec_valid;
  logic        irq_take;

  // irq_take deliberately ignores rom_jump_enable: the decoder derives that from rom_data.
  assign irq_take        = irq & ~in_isr & exec_valid & ~stall;
  assign rom_addr        = fetch_pc;
  assign rom_pc          = exec_pc;
  assign rom_data        = (~exec_valid | stall | irq_take) ? NOP_WORD : rom_q;
  assign irq_push_enable = irq_take;
  assign irq_push_data   = irq_take ? exec_pc : 11'h000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_VECTOR;
      exec_pc    <= 11'h000;
      exec_valid <= 1'b0;
      in_isr     <= 1'b0;
    end else begin
      if (interrupt_clear_status) begin
        in_isr <= 1'b0;
      end else if (irq_take) begin
        in_isr <= 1'b1;
      end

      if (!stall) begin
        exec_pc <= fetch_pc;
        if (irq_take) begin
          fetch_pc   <= IRQ_VECTOR;
          exec_valid <= 1'b0;
        end else if (rom_jump_enable && exec_valid) begin
          fetch_pc   <= rom_jump_data;
          exec_valid <= 1'b0;
        end else begin
          fetch_pc   <= fetch_pc + 11'd1;
          exec_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a tagged synchronous ROM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] rom_addr;
  logic [23:0] rom_q;
  logic [23:0] rom_data;
  logic [10:0] rom_pc;
  logic        rom_jump_enable;
  logic [10:0] rom_jump_data;
  logic        stall;
  logic        irq;
  logic        interrupt_clear_status;
  logic        irq_push_enable;
  logic [10:0] irq_push_data;
  logic        in_isr;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rom_addr               (rom_addr),
    .rom_q                  (rom_q),
    .rom_data               (rom_data),
    .rom_pc                 (rom_pc),
    .rom_jump_enable        (rom_jump_enable),
    .rom_jump_data          (rom_jump_data),
    .stall                  (stall),
    .irq                    (irq),
    .interrupt_clear_status (interrupt_clear_status),
    .irq_push_enable        (irq_push_enable),
    .irq_push_data          (irq_push_data),
    .in_isr                 (in_isr)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] tag(input logic [10:0] a);
    return {13'h1A5, a};
  endfunction

  always @(posedge clk) rom_q <= tag(rom_addr);

  task automatic chk(input string name, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rom_jump_enable = 1'b0;
    rom_jump_data = 11'h000;
    stall = 1'b0;
    irq = 1'b0;
    interrupt_clear_status = 1'b0;
    repeat (3) cyc();

    chk("rst_addr", 24'(rom_addr), 24'h000);
    chk("rst_data", rom_data, 24'h000000);
    chk("rst_pc", 24'(rom_pc), 24'h000);
    chk("rst_push_en", 24'(irq_push_enable), 24'h0);
    chk("rst_push_data", 24'(irq_push_data), 24'h000);
    chk("rst_in_isr", 24'(in_isr), 24'h0);

    rst_n = 1'b1;
    #1;
    chk("first_nop", rom_data, 24'h000000);

    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("seq_pc", 24'(rom_pc), 24'(i));
      chk("seq_data", rom_data, tag(11'(i)));
    end
    rom_jump_enable = 1'b1;
    rom_jump_data = 11'h123;
    cyc();
    rom_jump_enable = 1'b0;
    chk("jump_bubble", rom_data, 24'h000000);
    chk("jump_addr", 24'(rom_addr), 24'h123);
    cyc();
    chk("jump_pc", 24'(rom_pc), 24'h123);
    chk("jump_data", rom_data, tag(11'h123));

    rom_jump_enable = 1'b1;
    rom_jump_data = 11'd7;
    cyc();
    rom_jump_enable = 1'b0;
    chk("jump7_bubble", rom_data, 24'h000000);
    cyc();
    chk("pc7", 24'(rom_pc), 24'd7);
    cyc();
    chk("pc8", 24'(rom_pc), 24'd8);
    stall = 1'b1;
    #1;
    chk("stall_data", rom_data, 24'h000000);
    chk("stall_addr", 24'(rom_addr), 24'd9);
    chk("stall_pc", 24'(rom_pc), 24'd8);
    repeat (2) begin
      cyc();
      chk("stall_data", rom_data, 24'h000000);
      chk("stall_addr", 24'(rom_addr), 24'd9);
    end
    cyc();
    stall = 1'b0;
    #1;
    chk("unstall_pc", 24'(rom_pc), 24'd8);
    chk("unstall_addr", 24'(rom_addr), 24'd9);
    cyc();
    chk("after_stall_pc", 24'(rom_pc), 24'd9);
    chk("after_stall_data", rom_data, tag(11'd9));

    rom_jump_enable = 1'b1;
    rom_jump_data = 11'd20;
    cyc();
    rom_jump_enable = 1'b0;
    chk("jump20_bubble", rom_data, 24'h000000);
    cyc();
    chk("pc20", 24'(rom_pc), 24'd20);
    irq = 1'b1;
    #1;
    chk("irq_push_en", 24'(irq_push_enable), 24'h1);
    chk("irq_push_data", 24'(irq_push_data), 24'd20);
    chk("irq_squash", rom_data, 24'h000000);
    cyc();
    chk("irq_bubble", rom_data, 24'h000000);
    chk("irq_in_isr", 24'(in_isr), 24'h1);
    chk("irq_no_repush", 24'(irq_push_enable), 24'h0);
    chk("irq_vec_addr", 24'(rom_addr), 24'h010);
    cyc();
    chk("isr_pc", 24'(rom_pc), 24'h010);
    chk("isr_data", rom_data, tag(11'h010));
    chk("isr_masked", 24'(irq_push_enable), 24'h0);
    cyc();
    irq = 1'b0;
    interrupt_clear_status = 1'b1;
    cyc();
    interrupt_clear_status = 1'b0;
    chk("cis_in_isr", 24'(in_isr), 24'h0);
    chk("isr_pc12", 24'(rom_pc), 24'h012);
    rom_jump_enable = 1'b1;
    rom_jump_data = 11'd20;
    cyc();
    rom_jump_enable = 1'b0;
    chk("rtn_bubble", rom_data, 24'h000000);
    cyc();
    chk("rtn_pc", 24'(rom_pc), 24'd20);
    chk("rtn_data", rom_data, tag(11'd20));

    irq = 1'b1;
    #1;
    chk("irq2_push_en", 24'(irq_push_enable), 24'h1);
    cyc();
    chk("irq2_in_isr", 24'(in_isr), 24'h1);
    cyc();
    interrupt_clear_status = 1'b1;
    #1;
    chk("cis_irq_no_push", 24'(irq_push_enable), 24'h0);
    chk("cis_irq_data", rom_data, tag(11'h010));
    cyc();
    interrupt_clear_status = 1'b0;
    #1;
    chk("reenter_push_en", 24'(irq_push_enable), 24'h1);
    chk("reenter_push_data", 24'(irq_push_data), 24'h011);
    cyc();
    chk("reenter_bubble", rom_data, 24'h000000);
    chk("reenter_in_isr", 24'(in_isr), 24'h1);
    rst_n = 1'b0;
    irq = 1'b0;
    #1;
    chk("midrst_addr", 24'(rom_addr), 24'h000);
    chk("midrst_pc", 24'(rom_pc), 24'h000);
    chk("midrst_in_isr", 24'(in_isr), 24'h0);
    chk("midrst_push_en", 24'(irq_push_enable), 24'h0);
    chk("midrst_data", rom_data, 24'h000000);

    cyc();
    rst_n = 1'b1;
    #1;
    chk("rerel_nop", rom_data, 24'h000000);
    cyc();
    chk("rerel_pc0", 24'(rom_pc), 24'h000);
    rom_jump_enable = 1'b1;
    rom_jump_data = 11'h7FE;
    cyc();
    rom_jump_enable = 1'b0;
    chk("wrap_bubble", rom_data, 24'h000000);
    cyc();
    chk("pc7fe", 24'(rom_pc), 24'h7FE);
    cyc();
    chk("pc7ff", 24'(rom_pc), 24'h7FF);
    chk("wrap_addr", 24'(rom_addr), 24'h000);
    cyc();
    chk("wrap_pc", 24'(rom_pc), 24'h000);
    chk("wrap_data", rom_data, tag(11'h000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
